lsq_ring: RTL and testbench
===========================

Name: lsq_ring

Overview:
Parametrised circular load/store queue between the decode/dispatch stage and the data-memory port.
- Entries are allocated in program order and tagged by slot index.
- Entries are committed out of order by tag, and issued to memory strictly in order from the head once committed.
- Loads pushed behind an in-flight store to the same address receive forwarded data and retire without a memory access.

Parameters:
MEM_ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, data word width
ENTRIES, 16, queue depth; power of two, >= 2
TAG_WIDTH, $clog2(ENTRIES), localparam, slot index width

Ports:
clk  in  1  clock
sync_rst_n  in  1  synchronous active-low reset
clk_en  in  1  global clock enable; gates every state update
push_valid  in  1  allocate request
push_ready  out  1  = !full
push_is_store  in  1  0 load, 1 store
push_addr  in  MEM_ADDR_WIDTH  access address
push_data  in  DATA_WIDTH  store data (ignored for loads)
push_tag  out  TAG_WIDTH  slot allocated this cycle (= tail index)
fwd_hit  out  1  pushed load matched an older store
fwd_data  out  DATA_WIDTH  forwarded store data, valid with fwd_hit
commit_valid  in  1  commit request
commit_tag  in  TAG_WIDTH  slot to mark committed
mem_req_valid  out  1  head request valid
mem_req_ready  in  1  memory accepts request
mem_req_is_store  out  1  head op type
mem_req_addr  out  MEM_ADDR_WIDTH  head address
mem_req_data  out  DATA_WIDTH  head store data
mem_req_tag  out  TAG_WIDTH  head slot
count  out  TAG_WIDTH+1  occupied entries
full  out  1  count == ENTRIES
empty  out  1  count == 0

Behaviour:
- Clock and reset: one clock, clk. sync_rst_n is synchronous, active-low, and has priority over clk_en.
- Reset state: head/tail = 0; all valid, committed and forwarded bits cleared.
- Outputs immediately after reset: mem_req_valid=0, push_ready=1, empty=1, full=0, count=0, fwd_hit=0. Data outputs reflect slot 0, which is don't-care.
- clk_en=0: no pointer, flag or storage update. Combinational outputs still follow current state and inputs.
- Pointers: head and tail are TAG_WIDTH+1 bits; the MSB is a wrap bit.
  - full when indices are equal and wrap bits differ.
  - empty when both are fully equal.
  - count = tail - head, modulo 2^(TAG_WIDTH+1).
- Push:
  - Accepted when push_valid && push_ready && clk_en.
  - Writes the tail slot with valid=1 and committed=0, then increments tail.
  - push_tag is combinational and equals the tail index.
  - When full, push is rejected even if a pop occurs the same cycle, so push_ready never depends on mem_req_ready.
- Forwarding (combinational, push cycle only):
  - Applies only when a load is being pushed.
  - Searches valid store entries from tail-1 back to head for an exact address match; the youngest match wins.
  - Uncommitted stores participate. A store popping from the head in the same cycle still participates.
  - On a match: fwd_hit=1 and fwd_data = that store's data. The load is stored with forwarded=1 and its data field = fwd_data.
  - fwd_hit=0 whenever no load push is accepted.
- Commit:
  - commit_valid sets committed on slot commit_tag when that slot is valid. Commits to invalid slots are ignored.
  - A commit in cycle N is visible to issue no earlier than cycle N+1.
  - A commit to the tail slot in the same cycle it is pushed is ignored.
- Issue/retire at the head:
  - Head valid, committed, not forwarded: mem_req_valid=1. The entry pops (valid cleared, head+1) when mem_req_ready && clk_en.
  - Head valid, committed, forwarded: retires in one cycle with mem_req_valid=0, independent of mem_req_ready.
  - Head uncommitted: queue stalls. Younger committed entries never bypass it.
  - Exactly one pop per cycle maximum.
- Simultaneous push and pop: both take effect and count is unchanged. On an empty queue, a pushed entry cannot issue in its push cycle.
- Reset mid-operation: all entries are dropped and any in-flight mem_req handshake is abandoned. Memory must tolerate this.
- Wrap-around: indices wrap modulo ENTRIES; the wrap bit toggles on each wrap.

Decomposition:
- Shared package lsq_pkg: enum lsq_op_e {LSQ_LOAD=1'b0, LSQ_STORE=1'b1}; default width/depth localparams.
- The entry struct is declared inside the module, since it is parameter-dependent.
- One sub-module, lsq_fwd_match: combinational age-ordered priority search over the valid/is_store/addr vectors, rotated by head. Outputs hit and matching index.

Test Plan:
- Reset, then push 16 stores with addr=0x100+4i, data=i -> tags 0..15; full=1 and push_ready=0 after the 16th; a 17th push is rejected and count stays 16.
- Push load tag0 and store tag1; commit tag1, then tag0 -> no mem_req until tag0 commits. Then two requests in order: tag0 load, then tag1 store. mem_req_ready held low for 3 cycles stalls with stable outputs.
- Push store addr=0x40 data=0xAA, store addr=0x40 data=0xBB, then load addr=0x40 -> fwd_hit=1, fwd_data=0xBB. After all are committed, only 2 mem requests are issued; the load retires silently.
- Fill to 12, drain 8, push 10 -> tail wraps and tags continue 12..15, 0..5. count=14, then drain to empty=1 with issue order preserved.
- Full queue with head committed and mem_req_ready=1 plus push_valid=1 -> pop occurs, push rejected, count=15.
- Assert sync_rst_n low with clk_en=0 mid-traffic -> next cycle empty=1, mem_req_valid=0, count=0.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue: operation encoding and default sizing.
package lsq_pkg;

   typedef enum logic {
      LSQ_LOAD  = 1'b0,
      LSQ_STORE = 1'b1
   } lsq_op_e;

   localparam int LSQ_ADDR_WIDTH = 32;
   localparam int LSQ_DATA_WIDTH = 32;
   localparam int LSQ_ENTRIES    = 16;

endpackage

// File: rtl/lsq_fwd_match.sv
// Age-ordered store search for load forwarding. Walks the ring from the head
// (oldest) towards the tail, so the last match seen is the youngest store.
module lsq_fwd_match
   import lsq_pkg::*;
#(
   parameter int ENTRIES    = LSQ_ENTRIES,
   parameter int ADDR_WIDTH = LSQ_ADDR_WIDTH,
   localparam int TAG_WIDTH = $clog2(ENTRIES)
) (
   input  logic [ENTRIES-1:0]            valid_vec,
   input  logic [ENTRIES-1:0]            store_vec,
   input  logic [ENTRIES*ADDR_WIDTH-1:0] addr_flat,
   input  logic [TAG_WIDTH-1:0]          head_idx,
   input  logic [ADDR_WIDTH-1:0]         key_addr,
   output logic                          hit,
   output logic [TAG_WIDTH-1:0]          match_idx
);

   logic [TAG_WIDTH-1:0] idx;

   // Priority search oldest-to-youngest; later (younger) matches overwrite earlier ones.
   always_comb begin
      hit       = 1'b0;
      match_idx = head_idx;
      idx       = head_idx;
      for (int k = 0; k < ENTRIES; k++) begin
         idx = head_idx + TAG_WIDTH'(k);
         if (valid_vec[idx] && store_vec[idx] &&
             (addr_flat[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH] == key_addr)) begin
            hit       = 1'b1;
            match_idx = idx;
         end
      end
   end

endmodule

// File: rtl/lsq_ring.sv
// Circular load/store queue: in-order allocation, out-of-order commit by tag,
// in-order issue from the head, and store-to-load forwarding at push time.
module lsq_ring
   import lsq_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = LSQ_ADDR_WIDTH,
   parameter int DATA_WIDTH     = LSQ_DATA_WIDTH,
   parameter int ENTRIES        = LSQ_ENTRIES,
   localparam int TAG_WIDTH     = $clog2(ENTRIES)
) (
   input  logic                      clk,
   input  logic                      sync_rst_n,
   input  logic                      clk_en,
   input  logic                      push_valid,
   output logic                      push_ready,
   input  logic                      push_is_store,
   input  logic [MEM_ADDR_WIDTH-1:0] push_addr,
   input  logic [DATA_WIDTH-1:0]     push_data,
   output logic [TAG_WIDTH-1:0]      push_tag,
   output logic                      fwd_hit,
   output logic [DATA_WIDTH-1:0]     fwd_data,
   input  logic                      commit_valid,
   input  logic [TAG_WIDTH-1:0]      commit_tag,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_is_store,
   output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
   output logic [DATA_WIDTH-1:0]     mem_req_data,
   output logic [TAG_WIDTH-1:0]      mem_req_tag,
   output logic [TAG_WIDTH:0]        count,
   output logic                      full,
   output logic                      empty
);

   typedef struct packed {
      lsq_op_e                   op;
      logic [MEM_ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]     data;
   } entry_t;

   // Payload is never reset; the valid bits alone decide what is live.
   entry_t slot_q [ENTRIES];

   logic [TAG_WIDTH:0]   head_q, head_d, tail_q, tail_d;
   logic [ENTRIES-1:0]   valid_q, valid_d;
   logic [ENTRIES-1:0]   cmt_q, cmt_d;
   logic [ENTRIES-1:0]   fwd_q, fwd_d;
   logic [TAG_WIDTH-1:0] head_idx, tail_idx;
   logic                 push_fire, pop_fire, commit_fire, head_ready;
   logic                 match_hit;
   logic [TAG_WIDTH-1:0] match_idx;
   logic [ENTRIES-1:0]   store_vec;
   logic [ENTRIES*MEM_ADDR_WIDTH-1:0] addr_flat;

   assign head_idx = head_q[TAG_WIDTH-1:0];
   assign tail_idx = tail_q[TAG_WIDTH-1:0];

   assign full       = (head_idx == tail_idx) && (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);
   assign empty      = (head_q == tail_q);
   assign count      = tail_q - head_q;
   assign push_ready = !full;
   assign push_tag   = tail_idx;

   // Full blocks the push even if the head pops this cycle, keeping push_ready
   // independent of mem_req_ready.
   assign push_fire   = clk_en && push_valid && !full;
   assign commit_fire = clk_en && commit_valid && valid_q[commit_tag];

   assign head_ready    = valid_q[head_idx] && cmt_q[head_idx];
   assign mem_req_valid = head_ready && !fwd_q[head_idx];
   // Forwarded loads already have their data, so they retire without memory.
   assign pop_fire      = clk_en && head_ready && (fwd_q[head_idx] || mem_req_ready);

   assign mem_req_is_store = (slot_q[head_idx].op == LSQ_STORE);
   assign mem_req_addr     = slot_q[head_idx].addr;
   assign mem_req_data     = slot_q[head_idx].data;
   assign mem_req_tag      = head_idx;

   // Flatten slot addresses and op types for the forwarding search.
   always_comb begin
      addr_flat = '0;
      store_vec = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         addr_flat[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] = slot_q[i].addr;
         store_vec[i] = (slot_q[i].op == LSQ_STORE);
      end
   end

   lsq_fwd_match #(
      .ENTRIES    (ENTRIES),
      .ADDR_WIDTH (MEM_ADDR_WIDTH)
   ) u_fwd_match (
      .valid_vec (valid_q),
      .store_vec (store_vec),
      .addr_flat (addr_flat),
      .head_idx  (head_idx),
      .key_addr  (push_addr),
      .hit       (match_hit),
      .match_idx (match_idx)
   );

   assign fwd_hit  = push_fire && !push_is_store && match_hit;
   assign fwd_data = slot_q[match_idx].data;

   // Next-state for pointers and per-slot flags: commit, then pop, then push.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      cmt_d   = cmt_q;
      fwd_d   = fwd_q;
      if (commit_fire) begin
         cmt_d[commit_tag] = 1'b1;
      end
      if (pop_fire) begin
         valid_d[head_idx] = 1'b0;
         head_d            = head_q + 1'b1;
      end
      if (push_fire) begin
         valid_d[tail_idx] = 1'b1;
         cmt_d[tail_idx]   = 1'b0;
         fwd_d[tail_idx]   = fwd_hit;
         tail_d            = tail_q + 1'b1;
      end
   end

   // Pointer and flag registers; reset wins over clk_en.
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
         cmt_q   <= '0;
         fwd_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         cmt_q   <= cmt_d;
         fwd_q   <= fwd_d;
      end
   end

   // Payload write on push; a forwarded load keeps the store data it received.
   always_ff @(posedge clk) begin
      if (sync_rst_n && push_fire) begin
         slot_q[tail_idx].op   <= lsq_op_e'(push_is_store);
         slot_q[tail_idx].addr <= push_addr;
         slot_q[tail_idx].data <= fwd_hit ? fwd_data : push_data;
      end
   end

endmodule

// File: tb/tb_lsq_ring.sv
// Bench for lsq_ring: directed scenarios plus randomized traffic against a
// queue-based reference model of the load/store queue.
module tb_lsq_ring;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        sync_rst_n, clk_en;
   logic        push_valid, push_ready, push_is_store;
   logic [31:0] push_addr, push_data;
   logic [3:0]  push_tag;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        commit_valid;
   logic [3:0]  commit_tag;
   logic        mem_req_valid, mem_req_ready, mem_req_is_store;
   logic [31:0] mem_req_addr, mem_req_data;
   logic [3:0]  mem_req_tag;
   logic [4:0]  count;
   logic        full, empty;

   int n_checks;
   int n_errors;

   always #5 clk = ~clk;

   lsq_ring dut (
      .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en),
      .push_valid(push_valid), .push_ready(push_ready), .push_is_store(push_is_store),
      .push_addr(push_addr), .push_data(push_data), .push_tag(push_tag),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .commit_valid(commit_valid), .commit_tag(commit_tag),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_is_store(mem_req_is_store), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .count(count), .full(full), .empty(empty)
   );

   // Reference model: program-ordered list of live entries, oldest first.
   typedef struct {
      int          tag;
      bit          st;
      logic [31:0] addr;
      logic [31:0] data;
      bit          cm;
      bit          fw;
   } m_ent_t;

   m_ent_t mq[$];
   int     m_tail;

   function automatic void m_fwd(output bit hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      if (push_valid && clk_en && !push_is_store && mq.size() < N) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].st && mq[i].addr == push_addr) begin
               hit = 1'b1;
               d   = mq[i].data;
               break;
            end
         end
      end
   endfunction

   function automatic void m_update();
      bit          do_pop, do_push, hit;
      logic [31:0] fd;
      m_ent_t      e;
      if (!sync_rst_n) begin
         mq.delete();
         m_tail = 0;
         return;
      end
      if (!clk_en) return;
      do_pop  = (mq.size() > 0) && mq[0].cm && (mq[0].fw || mem_req_ready);
      do_push = push_valid && (mq.size() < N);
      m_fwd(hit, fd);
      if (commit_valid)
         foreach (mq[i]) if (mq[i].tag == int'(commit_tag)) mq[i].cm = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         e.tag  = m_tail;
         e.st   = push_is_store;
         e.addr = push_addr;
         e.data = hit ? fd : push_data;
         e.cm   = 1'b0;
         e.fw   = hit;
         mq.push_back(e);
         m_tail = (m_tail + 1) % N;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic idle_inputs();
      sync_rst_n = 1'b1; clk_en = 1'b1;
      push_valid = 1'b0; push_is_store = 1'b0; push_addr = '0; push_data = '0;
      commit_valid = 1'b0; commit_tag = '0; mem_req_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      sync_rst_n = 1'b0;
      tick();
      sync_rst_n = 1'b1;
   endtask

   task automatic push1(input bit st, input logic [31:0] a, input logic [31:0] d);
      push_valid = 1'b1; push_is_store = st; push_addr = a; push_data = d;
      tick();
      push_valid = 1'b0;
   endtask

   task automatic commit1(input int t);
      commit_valid = 1'b1; commit_tag = t[3:0];
      tick();
      commit_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", full); end
      n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (push_ready !== 1'b1) begin n_errors++; $display("FAIL reset_push_ready: got %b want 1", push_ready); end
      n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
      n_checks++; if (fwd_hit !== 1'b0) begin n_errors++; $display("FAIL reset_fwd_hit: got %b want 0", fwd_hit); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < N; i++) begin
         push_valid = 1'b1; push_is_store = 1'b1; push_addr = 32'h100 + 32'(4*i); push_data = 32'(i);
         @(negedge clk);
         n_checks++; if (push_tag !== 4'(i)) begin n_errors++; $display("FAIL fill_tag: got %0d want %0d", push_tag, i); end
         tick();
      end
      push_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL fill_full: got %b want 1", full); end
      n_checks++; if (push_ready !== 1'b0) begin n_errors++; $display("FAIL fill_push_ready: got %b want 0", push_ready); end
      n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL fill_count: got %0d want 16", count); end
      push1(1'b1, 32'h500, 32'h77);
      @(negedge clk);
      n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL fill_reject_count: got %0d want 16", count); end
   endtask

   task automatic test_commit_order();
      do_reset();
      push1(1'b0, 32'h200, 32'h0);
      push1(1'b1, 32'h300, 32'h55);
      mem_req_ready = 1'b1;
      commit1(1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL order_stall_valid: got %b want 0", mem_req_valid); end
         tick();
      end
      mem_req_ready = 1'b0;
      commit1(0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (mem_req_valid !== 1'b1 || mem_req_tag !== 4'd0 || mem_req_is_store !== 1'b0 || mem_req_addr !== 32'h200) begin
            n_errors++;
            $display("FAIL order_hold: got v=%b tag=%0d st=%b addr=%h want v=1 tag=0 st=0 addr=200",
                     mem_req_valid, mem_req_tag, mem_req_is_store, mem_req_addr);
         end
         tick();
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (mem_req_valid !== 1'b1 || mem_req_tag !== 4'd0) begin n_errors++; $display("FAIL order_first: got v=%b tag=%0d want v=1 tag=0", mem_req_valid, mem_req_tag); end
      tick();
      @(negedge clk);
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_tag !== 4'd1 || mem_req_is_store !== 1'b1 ||
          mem_req_addr !== 32'h300 || mem_req_data !== 32'h55) begin
         n_errors++;
         $display("FAIL order_second: got v=%b tag=%0d st=%b addr=%h data=%h want v=1 tag=1 st=1 addr=300 data=55",
                  mem_req_valid, mem_req_tag, mem_req_is_store, mem_req_addr, mem_req_data);
      end
      tick();
      @(negedge clk);
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL order_empty: got %b want 1", empty); end
      mem_req_ready = 1'b0;
   endtask

   task automatic test_forward();
      int issued;
      do_reset();
      push1(1'b1, 32'h40, 32'hAA);
      push1(1'b1, 32'h40, 32'hBB);
      push_valid = 1'b1; push_is_store = 1'b0; push_addr = 32'h40; push_data = 32'h0;
      @(negedge clk);
      n_checks++; if (fwd_hit !== 1'b1) begin n_errors++; $display("FAIL fwd_hit: got %b want 1", fwd_hit); end
      n_checks++; if (fwd_data !== 32'hBB) begin n_errors++; $display("FAIL fwd_data: got %h want bb", fwd_data); end
      tick();
      push_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (fwd_hit !== 1'b0) begin n_errors++; $display("FAIL fwd_idle: got %b want 0", fwd_hit); end
      commit1(2); commit1(0); commit1(1);
      mem_req_ready = 1'b1;
      issued = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (empty) break;
         if (mem_req_valid) issued++;
         tick();
      end
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL fwd_drain_timeout: empty=%b want 1", empty); end
      n_checks++; if (issued != 2) begin n_errors++; $display("FAIL fwd_mem_reqs: got %0d want 2", issued); end
      mem_req_ready = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 12; i++) push1(1'b1, 32'h1000 + 32'(4*i), $urandom);
      for (int i = 0; i < 12; i++) commit1(i);
      mem_req_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_checks++; if (mem_req_valid !== 1'b1 || mem_req_tag !== 4'(k)) begin n_errors++; $display("FAIL wrap_drain8: got v=%b tag=%0d want v=1 tag=%0d", mem_req_valid, mem_req_tag, k); end
         tick();
      end
      mem_req_ready = 1'b0;
      for (int j = 0; j < 10; j++) begin
         push_valid = 1'b1; push_is_store = 1'b1; push_addr = 32'h2000 + 32'(4*j); push_data = $urandom;
         @(negedge clk);
         n_checks++; if (push_tag !== 4'((12 + j) % N)) begin n_errors++; $display("FAIL wrap_tag: got %0d want %0d", push_tag, (12 + j) % N); end
         tick();
      end
      push_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (count !== 5'd14) begin n_errors++; $display("FAIL wrap_count: got %0d want 14", count); end
      for (int j = 0; j < 10; j++) commit1((12 + j) % N);
      mem_req_ready = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         n_checks++; if (mem_req_valid !== 1'b1 || mem_req_tag !== 4'((8 + k) % N)) begin n_errors++; $display("FAIL wrap_order: got v=%b tag=%0d want v=1 tag=%0d", mem_req_valid, mem_req_tag, (8 + k) % N); end
         tick();
      end
      @(negedge clk);
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
      mem_req_ready = 1'b0;
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < N; i++) push1(1'b1, 32'h3000 + 32'(4*i), 32'(i));
      commit1(0);
      push_valid = 1'b1; push_is_store = 1'b1; push_addr = 32'h4000; push_data = 32'h9;
      mem_req_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (push_ready !== 1'b0) begin n_errors++; $display("FAIL fullpop_ready: got %b want 0", push_ready); end
      n_checks++; if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL fullpop_req: got %b want 1", mem_req_valid); end
      tick();
      push_valid = 1'b0; mem_req_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (count !== 5'd15) begin n_errors++; $display("FAIL fullpop_count: got %0d want 15", count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      push1(1'b1, 32'h10, 32'h1);
      push1(1'b0, 32'h20, 32'h0);
      push1(1'b1, 32'h30, 32'h3);
      commit1(0);
      sync_rst_n = 1'b0; clk_en = 1'b0; push_valid = 1'b1; push_is_store = 1'b1;
      tick();
      sync_rst_n = 1'b1; clk_en = 1'b1; push_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL midrst_empty: got %b want 1", empty); end
      n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_req: got %b want 0", mem_req_valid); end
      n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL midrst_count: got %0d want 0", count); end
   endtask

   task automatic test_random();
      bit          eh, ereq;
      logic [31:0] ed;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         sync_rst_n    = ($urandom_range(0, 199) != 0);
         clk_en        = ($urandom_range(0, 9) != 0);
         push_valid    = $urandom_range(0, 1);
         push_is_store = $urandom_range(0, 1);
         push_addr     = 32'($urandom_range(0, 5)) << 2;
         push_data     = $urandom;
         commit_valid  = ($urandom_range(0, 2) != 0);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            commit_tag = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
         else
            commit_tag = 4'($urandom_range(0, N - 1));
         mem_req_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         m_fwd(eh, ed);
         ereq = (mq.size() > 0) && mq[0].cm && !mq[0].fw;
         n_checks++; if (count !== 5'(mq.size())) begin n_errors++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, count, mq.size()); end
         n_checks++; if (full !== (mq.size() == N) || empty !== (mq.size() == 0) || push_ready !== (mq.size() != N)) begin
            n_errors++; $display("FAIL rnd_flags cyc %0d: got full=%b empty=%b ready=%b for size %0d", cyc, full, empty, push_ready, mq.size()); end
         n_checks++; if (push_tag !== 4'(m_tail)) begin n_errors++; $display("FAIL rnd_push_tag cyc %0d: got %0d want %0d", cyc, push_tag, m_tail); end
         n_checks++; if (fwd_hit !== eh) begin n_errors++; $display("FAIL rnd_fwd_hit cyc %0d: got %b want %b", cyc, fwd_hit, eh); end
         if (eh) begin
            n_checks++; if (fwd_data !== ed) begin n_errors++; $display("FAIL rnd_fwd_data cyc %0d: got %h want %h", cyc, fwd_data, ed); end
         end
         n_checks++; if (mem_req_valid !== ereq) begin n_errors++; $display("FAIL rnd_req_valid cyc %0d: got %b want %b", cyc, mem_req_valid, ereq); end
         if (ereq) begin
            n_checks++;
            if (mem_req_tag !== 4'(mq[0].tag) || mem_req_is_store !== mq[0].st || mem_req_addr !== mq[0].addr ||
                (mq[0].st && mem_req_data !== mq[0].data)) begin
               n_errors++;
               $display("FAIL rnd_req_fields cyc %0d: got tag=%0d st=%b addr=%h data=%h want tag=%0d st=%b addr=%h data=%h",
                        cyc, mem_req_tag, mem_req_is_store, mem_req_addr, mem_req_data,
                        mq[0].tag, mq[0].st, mq[0].addr, mq[0].data);
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_tail   = 0;
      idle_inputs();
      test_reset();
      test_fill();
      test_commit_order();
      test_forward();
      test_wrap();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
